// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : shared UART receiver types, defaults and bit-timing helper.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  localparam int UART_CLK_FREQ  = 50_000_000;
  localparam int UART_DATA_BITS = 8;

  // Rounded to nearest so the accumulated sampling drift stays symmetric.
  function automatic int uart_clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo : byte FIFO, single push port, N-byte pop window.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int N     = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_push,
  input  logic [7:0]               i_push_data,
  input  logic [$clog2(N+1)-1:0]   i_pop,
  output logic [N-1:0][7:0]        o_data,
  output logic [$clog2(N+1)-1:0]   o_can_pop
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int POP_W = $clog2(N + 1);

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_count;

  logic [POP_W-1:0] w_pop_eff;
  logic [PTR_W-1:0] w_wr;
  logic             w_push_ok;
  int               w_after_pop;

  // Operands never exceed 2*DEPTH-1, so one conditional subtract wraps any DEPTH.
  function automatic logic [PTR_W-1:0] wrap_idx(input int a);
    int r;
    r = (a >= DEPTH) ? a - DEPTH : a;
    return r[PTR_W-1:0];
  endfunction

  always_comb begin
    o_can_pop   = (int'(r_count) < N) ? POP_W'(r_count) : POP_W'(N);
    w_pop_eff   = (i_pop < o_can_pop) ? i_pop : o_can_pop;
    w_after_pop = int'(r_count) - int'(w_pop_eff);
    w_push_ok   = i_push && (w_after_pop < DEPTH);
    w_wr        = wrap_idx(int'(r_rd) + int'(r_count));
    for (int k = 0; k < N; k++) begin
      o_data[k] = r_mem[wrap_idx(int'(r_rd) + k)];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push_ok) begin
        r_mem[w_wr] <= i_push_data;
      end
      r_rd    <= wrap_idx(int'(r_rd) + int'(w_pop_eff));
      r_count <= CNT_W'(w_after_pop + (w_push_ok ? 1 : 0));
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : 8N1 oversampling receiver feeding a multi-pop byte FIFO.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int boadrate = 115200,
  parameter int CLK_FREQ = UART_CLK_FREQ,
  parameter int DEPTH    = 4,
  parameter int N        = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rx,
  output logic [N-1:0][7:0]        data,
  input  logic [$clog2(N+1)-1:0]   pop,
  output logic [$clog2(N+1)-1:0]   can_pop
);

  localparam int CLKS_PER_BIT = uart_clks_per_bit(CLK_FREQ, boadrate);
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [1:0] S_IDLE  = UART_IDLE;
  localparam logic [1:0] S_START = UART_START;
  localparam logic [1:0] S_DATA  = UART_DATA;
  localparam logic [1:0] S_STOP  = UART_STOP;

  logic [1:0]       r_sync;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic             r_ferr;

  logic w_rx_s;
  logic w_bit_done;
  logic w_push;

  assign w_rx_s     = r_sync[1];
  assign w_bit_done = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
  // Push on the stop-sample edge itself so a following start edge is never missed.
  assign w_push     = (r_state == S_STOP) && !r_ferr && w_bit_done && w_rx_s;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_ferr  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s) begin
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_cnt == CNT_W'(HALF - 1)) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= w_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_done) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[7:1]};
            r_idx   <= r_idx + 1'b1;
            if (r_idx == 3'(UART_DATA_BITS - 1)) begin
              r_state <= S_STOP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_ferr) begin
            if (w_rx_s) begin
              r_ferr  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else if (w_bit_done) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_state <= S_IDLE;
            end else begin
              r_ferr <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .N     (N)
  ) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .i_push      (w_push),
    .i_push_data (r_shift),
    .i_pop       (pop),
    .o_data      (data),
    .o_can_pop   (can_pop)
  );

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx : scoreboard bench for uart_rx (16 clocks per bit).  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;

  localparam int CLK_FREQ  = 1_843_200;
  localparam int BAUD      = 115200;
  localparam int DEPTH     = 4;
  localparam int N         = 4;
  localparam int CPB       = 16;
  localparam int HALF      = CPB / 2;
  // rx low driven just after edge 0: 2 sync edges, 1 IDLE edge, half bit, 9 full bits.
  localparam int PUSH_EDGE = 3 + HALF + 9 * CPB;

  logic             clk  = 1'b0;
  logic             rstn = 1'b0;
  logic             rx   = 1'b1;
  logic [N-1:0][7:0] data;
  logic [2:0]       pop  = '0;
  logic [2:0]       can_pop;

  int n_checks  = 0;
  int n_errors  = 0;
  int exp_q[$];
  bit mon_en    = 1'b0;
  int cp_cycles = 0;

  uart_rx #(
    .boadrate (BAUD),
    .CLK_FREQ (CLK_FREQ),
    .DEPTH    (DEPTH),
    .N        (N)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .rx      (rx),
    .data    (data),
    .pop     (pop),
    .can_pop (can_pop)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(CPB);
    end
    rx = stop_bit;
    step(CPB);
    rx = 1'b1;
  endtask

  task automatic check_window(input string tag);
    for (int k = 0; k < exp_q.size() && k < N; k++) begin
      check_eq(tag, int'(data[k]), exp_q[k]);
    end
  endtask

  // Consumer side of the scoreboard: every lane actually popped is checked.
  always @(negedge clk) begin
    if (mon_en && rstn) begin
      int n;
      if (can_pop != 0) cp_cycles++;
      n = (pop < can_pop) ? int'(pop) : int'(can_pop);
      for (int k = 0; k < n; k++) begin
        if (exp_q.size() == 0) check_eq("sb_underrun", exp_q.size(), 1);
        else check_eq("sb_data", int'(data[k]), exp_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset
    rstn = 1'b0;
    rx   = 1'b1;
    step(3);
    check_eq("reset_can_pop", int'(can_pop), 0);
    check_eq("reset_data", int'(data), 0);
    rstn = 1'b1;
    step(2);
    check_eq("post_reset_can_pop", int'(can_pop), 0);

    // Single byte with pop=4 held
    pop = 3'd4;
    mon_en = 1'b1;
    cp_cycles = 0;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    step(CPB);
    check_eq("single_drain", exp_q.size(), 0);
    check_eq("single_cp_cycles", cp_cycles, 1);
    check_eq("single_cp_after", int'(can_pop), 0);

    // Back-to-back stream, then partial pop
    mon_en = 1'b0;
    pop = 3'd0;
    foreach (exp_q[i]) exp_q.delete(i);
    begin
      logic [7:0] bytes [4];
      bytes = '{8'h55, 8'hF0, 8'hF0, 8'hF0};
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back(bytes[i]);
        send_frame(bytes[i], 1'b1);
      end
    end
    step(4);
    check_eq("stream_can_pop", int'(can_pop), 4);
    check_window("stream_data");
    pop = 3'd2;
    step(1);
    pop = 3'd0;
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    check_eq("stream_pop2_can_pop", int'(can_pop), 2);
    check_window("stream_pop2_data");
    pop = 3'd4;
    mon_en = 1'b1;
    step(2);
    mon_en = 1'b0;
    pop = 3'd0;
    check_eq("stream_drain", exp_q.size(), 0);
    check_eq("stream_empty", int'(can_pop), 0);

    // Overflow: fifth byte must be dropped
    for (int v = 1; v <= 5; v++) begin
      if (v <= DEPTH) exp_q.push_back(v);
      send_frame(8'(v), 1'b1);
    end
    step(4);
    check_eq("ovf_can_pop", int'(can_pop), 4);
    check_window("ovf_data");

    // Full FIFO: push and pop on the same edge keeps the count and accepts the byte
    fork
      send_frame(8'hC3, 1'b1);
      begin
        repeat (PUSH_EDGE - 1) @(posedge clk);
        #1 pop = 3'd1;
        @(posedge clk);
        #1 pop = 3'd0;
      end
    join
    void'(exp_q.pop_front());
    exp_q.push_back(8'hC3);
    step(2);
    check_eq("simul_can_pop", int'(can_pop), 4);
    check_window("simul_data");
    pop = 3'd4;
    mon_en = 1'b1;
    step(2);
    check_eq("simul_drain", exp_q.size(), 0);

    // Framing error: no push, then recovery
    cp_cycles = 0;
    send_frame(8'h00, 1'b0);
    step(CPB);
    check_eq("frame_no_push", cp_cycles, 0);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    step(CPB);
    check_eq("frame_recover", exp_q.size(), 0);

    // 0.2-bit glitch on idle line
    cp_cycles = 0;
    rx = 1'b0;
    step(3);
    rx = 1'b1;
    step(2 * CPB);
    check_eq("glitch_no_push", cp_cycles, 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    step(CPB);
    check_eq("glitch_recover", exp_q.size(), 0);

    // Reset in the middle of a frame loses the partial byte
    cp_cycles = 0;
    rx = 1'b0;
    step(CPB);
    rx = 1'b1;
    step(2 * CPB);
    rstn = 1'b0;
    step(2);
    rstn = 1'b1;
    step(8 * CPB);
    check_eq("midreset_no_push", cp_cycles, 0);
    check_eq("midreset_can_pop", int'(can_pop), 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    step(CPB);
    check_eq("midreset_recover", exp_q.size(), 0);

    // Stream with pop=1 across several pointer wraps
    pop = 3'd1;
    for (int i = 0; i < 12; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(b, 1'b1);
    end
    step(CPB);
    check_eq("wrap_drain", exp_q.size(), 0);
    check_eq("wrap_empty", int'(can_pop), 0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
